// File: rtl/wb_bot_poller_if.sv
// Wishbone classic bus between the bot poller (master) and the Rojobot register block (slave).
// Signal map: adr/wdat/sel/we/cyc/stb/cti/bte = wb_*_o, rdat/ack/err = wb_dat_i/wb_ack_i/wb_err_i.
interface wb_bot_poller_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    output adr, wdat, sel, we, cyc, stb, cti, bte,
    input  rdat, ack, err
  );

  modport slave (
    input  adr, wdat, sel, we, cyc, stb, cti, bte,
    output rdat, ack, err
  );
endinterface

// File: rtl/wb_bot_poller.sv
// Hardware Wishbone initiator that polls the Rojobot update-sync register, fetches bot info,
// acknowledges the update and writes the motor command. Define WB_POLL_TIMEOUT_EN to build the ack timeout.
module wb_bot_poller #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [7:0]  motor_cmd,
  input  logic        err_clr,
  output logic [31:0] bot_info,
  output logic        info_valid,
  output logic [15:0] upd_count,
  output logic        busy,
  output logic        bus_err,
  wb_bot_poller_if.master wb
);

  typedef enum logic [2:0] {
    IDLE, GAP, RD_SYNC, RD_INFO, WR_ACK1, WR_ACK0, WR_CTRL
  } state_t;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } req_t;

  localparam logic [31:0] OFS_INFO    = 32'h0000_000C;
  localparam logic [31:0] OFS_CTRL    = 32'h0000_0010;
  localparam logic [31:0] OFS_SYNC    = 32'h0000_0014;
  localparam logic [31:0] OFS_UPD_ACK = 32'h0000_0018;
  localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);

  // Bus request issued on entry to each transfer state.
  function automatic req_t req_for(state_t s, logic [7:0] cmd);
    req_t r;
    r = '{adr: BASE_ADDR + OFS_SYNC, we: 1'b0, dat: 32'h0};
    case (s)
      RD_INFO: r.adr = BASE_ADDR + OFS_INFO;
      WR_ACK1: begin
        r.adr = BASE_ADDR + OFS_UPD_ACK;
        r.we  = 1'b1;
        r.dat = 32'h1;
      end
      WR_ACK0: begin
        r.adr = BASE_ADDR + OFS_UPD_ACK;
        r.we  = 1'b1;
      end
      WR_CTRL: begin
        r.adr = BASE_ADDR + OFS_CTRL;
        r.we  = 1'b1;
        r.dat = {24'h0, cmd};
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic state_t follow_of(state_t s, logic hit);
    case (s)
      RD_SYNC: return hit ? RD_INFO : GAP;
      RD_INFO: return WR_ACK1;
      WR_ACK1: return WR_ACK0;
      WR_ACK0: return WR_CTRL;
      default: return GAP;
    endcase
  endfunction

  state_t      state;
  logic        done;       // transfer acked; this cycle is the mandatory cyc=0 turnaround
  logic        sync_hit;
  logic [7:0]  gap_cnt;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wdat_q;

  logic        xfer_wait;
  logic        timeout_hit;
  logic        abort;
  logic        launch;
  state_t      launch_to;
  state_t      follow;
  req_t        req;

`ifdef WB_POLL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_wait = (state != IDLE) && (state != GAP) && !done;
  assign abort     = xfer_wait && (wb.err || timeout_hit);
  assign follow    = follow_of(state, sync_hit);
  assign req       = req_for(launch_to, motor_cmd);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    launch    = 1'b0;
    launch_to = RD_SYNC;
    case (state)
      IDLE:    launch = enable;
      GAP:     launch = (gap_cnt == GAP_LAST) && enable;
      default: begin
        if (done) begin
          launch_to = follow;
          launch    = (follow != GAP);
        end
      end
    endcase
  end

  assign wb.cyc  = cyc_q;
  assign wb.stb  = cyc_q;
  assign wb.sel  = {3'b000, cyc_q};
  assign wb.we   = we_q;
  assign wb.adr  = adr_q;
  assign wb.wdat = wdat_q;
  assign wb.cti  = 3'b000;
  assign wb.bte  = 2'b00;
  assign busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this
  // block override earlier ones, which is how a new error beats a same-cycle err_clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      done       <= 1'b0;
      sync_hit   <= 1'b0;
      gap_cnt    <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      bot_info   <= '0;
      info_valid <= 1'b0;
      upd_count  <= '0;
      bus_err    <= 1'b0;
`ifdef WB_POLL_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      info_valid <= 1'b0;
      if (err_clr) bus_err <= 1'b0;

      if (launch) begin
        state  <= launch_to;
        cyc_q  <= 1'b1;
        adr_q  <= req.adr;
        we_q   <= req.we;
        wdat_q <= req.dat;
        done   <= 1'b0;
`ifdef WB_POLL_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: ;
          GAP: begin
            if (gap_cnt == GAP_LAST) state <= IDLE;
            else                     gap_cnt <= gap_cnt + 8'd1;
          end
          default: begin
            if (done) begin
              done    <= 1'b0;
              state   <= GAP;
              gap_cnt <= '0;
            end else if (abort) begin
              cyc_q   <= 1'b0;
              we_q    <= 1'b0;
              adr_q   <= '0;
              wdat_q  <= '0;
              bus_err <= 1'b1;
              state   <= GAP;
              gap_cnt <= '0;
            end else if (wb.ack) begin
              cyc_q  <= 1'b0;
              we_q   <= 1'b0;
              adr_q  <= '0;
              wdat_q <= '0;
              done   <= 1'b1;
              case (state)
                RD_SYNC: sync_hit <= wb.rdat[0];
                RD_INFO: begin
                  bot_info   <= wb.rdat;
                  info_valid <= 1'b1;
                end
                WR_CTRL: upd_count <= upd_count + 16'd1;
                default: ;
              endcase
            end
`ifdef WB_POLL_TIMEOUT_EN
            else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_bot_poller.sv
// Directed self-checking bench for wb_bot_poller against a register-block slave that acks
// one cycle after cyc. The timeout scenario runs only when WB_POLL_TIMEOUT_EN is defined.
module tb_wb_bot_poller;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  motor_cmd = 8'h33;
  logic        err_clr = 1'b0;
  logic [31:0] bot_info;
  logic        info_valid;
  logic [15:0] upd_count;
  logic        busy;
  logic        bus_err;

  wb_bot_poller_if wb();

  wb_bot_poller dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .motor_cmd (motor_cmd),
    .err_clr   (err_clr),
    .bot_info  (bot_info),
    .info_valid(info_valid),
    .upd_count (upd_count),
    .busy      (busy),
    .bus_err   (bus_err),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          start;
  } txn_t;

  int compared = 0;
  int mismatched = 0;

  // Slave-side state (written only by the slave process).
  txn_t        tx_q[$];
  int          cnt = 0;
  int          iv_cnt = 0;
  logic [31:0] iv_data = '0;
  bit          seen = 1'b0;
  int          cur_start = 0;
  int          sync_acks = 0;

  // Scenario controls (written only by the stimulus process).
  int          sync_sets = 0;
  bit          hang_info = 1'b0;
  bit          err_ctrl = 1'b0;
  logic [31:0] info_word = '0;

  // Register-block model: ack one cycle after cyc is seen, sync bit clears on 0x18<-1.
  always begin
    @(posedge clk);
    #1;
    cnt++;
    if (info_valid) begin
      iv_cnt++;
      iv_data = bot_info;
    end
    if (!rstn) begin
      wb.ack  = 1'b0;
      wb.err  = 1'b0;
      wb.rdat = '0;
      seen    = 1'b0;
    end else begin
      if (wb.cyc && !seen) cur_start = cnt;
      if (wb.cyc && seen && !wb.ack && !wb.err && !(hang_info && wb.adr == 32'h0C)) begin
        if (err_ctrl && wb.adr == 32'h10) begin
          wb.err = 1'b1;
        end else begin
          wb.ack = 1'b1;
          if (wb.adr == 32'h14)      wb.rdat = {31'b0, (sync_sets != sync_acks)};
          else if (wb.adr == 32'h0C) wb.rdat = info_word;
          else                       wb.rdat = '0;
          if (wb.we && wb.adr == 32'h18 && wb.wdat[0]) sync_acks++;
        end
        tx_q.push_back('{adr: wb.adr, we: wb.we, dat: wb.wdat, sel: wb.sel, start: cur_start});
      end else begin
        wb.ack = 1'b0;
        wb.err = 1'b0;
      end
      seen = wb.cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_txns(input int n, input int budget, input string tag);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_xfer(input logic [31:0] adr, input int budget, input string tag);
    int i = 0;
    while (!(wb.cyc && wb.adr == adr) && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(wb.cyc && wb.adr == adr), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int iv0;
    int exp_upd;
    int n;
    logic [31:0] exp_adr [6];
    logic        exp_we  [6];
    logic [31:0] exp_dat [6];
    int          exp_off [6];

    exp_adr = '{32'h14, 32'h0C, 32'h18, 32'h18, 32'h10, 32'h14};
    exp_we  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_dat = '{32'h0, 32'h0, 32'h1, 32'h0, 32'h33, 32'h0};
    exp_off = '{0, 3, 6, 9, 12, 31};
    exp_upd = 0;

    // Reset state
    tick(3);
    check("rst_cyc",  {31'b0, wb.cyc}, 32'd0);
    check("rst_stb",  {31'b0, wb.stb}, 32'd0);
    check("rst_sel",  {28'b0, wb.sel}, 32'd0);
    check("rst_adr",  wb.adr, 32'd0);
    check("rst_we",   {31'b0, wb.we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err",  {31'b0, bus_err}, 32'd0);
    check("rst_upd",  {16'b0, upd_count}, 32'd0);
    check("rst_info", bot_info, 32'd0);
    check("rst_iv",   {31'b0, info_valid}, 32'd0);
    rstn = 1'b1;
    tick(2);
    check("idle_no_enable", {31'b0, busy}, 32'd0);

    // Idle poll: sync reads 0, read / 16-cycle gap / read, no writes
    base = tx_q.size();
    enable = 1'b1;
    wait_txns(base + 2, 100, "idle_wait");
    check("idle_adr0", tx_q[base].adr, 32'h14);
    check("idle_we0",  {31'b0, tx_q[base].we}, 32'd0);
    check("idle_adr1", tx_q[base + 1].adr, 32'h14);
    check("idle_we1",  {31'b0, tx_q[base + 1].we}, 32'd0);
    check("idle_period", 32'(tx_q[base + 1].start - tx_q[base].start), 32'd19);
    check("idle_upd", {16'b0, upd_count}, 32'd0);

    // Full update sequence
    enable = 1'b0;
    wait_idle(100, "upd_pre_idle");
    base = tx_q.size();
    iv0 = iv_cnt;
    info_word = 32'h2A3B_0C05;
    sync_sets++;
    enable = 1'b1;
    wait_txns(base + 6, 200, "upd_wait");
    for (int i = 0; i < 6; i++) begin
      check($sformatf("upd_adr%0d", i), tx_q[base + i].adr, exp_adr[i]);
      check($sformatf("upd_we%0d", i), {31'b0, tx_q[base + i].we}, {31'b0, exp_we[i]});
      check($sformatf("upd_sel%0d", i), {28'b0, tx_q[base + i].sel}, 32'd1);
      check($sformatf("upd_start%0d", i), 32'(tx_q[base + i].start - tx_q[base].start), 32'(exp_off[i]));
      if (exp_we[i]) check($sformatf("upd_dat%0d", i), tx_q[base + i].dat, exp_dat[i]);
    end
    exp_upd++;
    check("upd_info", bot_info, 32'h2A3B_0C05);
    check("upd_iv_pulses", 32'(iv_cnt - iv0), 32'd1);
    check("upd_iv_data", iv_data, 32'h2A3B_0C05);
    check("upd_count", {16'b0, upd_count}, 32'(exp_upd));
    check("upd_no_err", {31'b0, bus_err}, 32'd0);

    // Bus error on the WR_CTRL transfer
    enable = 1'b0;
    wait_idle(100, "berr_pre_idle");
    base = tx_q.size();
    err_ctrl = 1'b1;
    info_word = 32'h1122_3344;
    sync_sets++;
    enable = 1'b1;
    wait_txns(base + 6, 200, "berr_wait");
    err_ctrl = 1'b0;
    check("berr_ctrl_adr", tx_q[base + 4].adr, 32'h10);
    check("berr_ctrl_start", 32'(tx_q[base + 4].start - tx_q[base].start), 32'd12);
    check("berr_resume", 32'(tx_q[base + 5].start - tx_q[base].start), 32'd30);
    check("berr_flag", {31'b0, bus_err}, 32'd1);
    check("berr_upd", {16'b0, upd_count}, 32'(exp_upd));
    check("berr_info", bot_info, 32'h1122_3344);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("berr_clear", {31'b0, bus_err}, 32'd0);

`ifdef WB_POLL_TIMEOUT_EN
    // Timeout: the info read is never acked
    enable = 1'b0;
    wait_idle(100, "tmo_pre_idle");
    hang_info = 1'b1;
    info_word = 32'hDEAD_BEEF;
    sync_sets++;
    enable = 1'b1;
    wait_xfer(32'h0C, 100, "tmo_start");
    n = 1;
    for (int i = 0; i < 300 && wb.cyc; i++) begin
      tick();
      if (wb.cyc) n++;
    end
    check("tmo_cycles", 32'(n), 32'd64);
    check("tmo_flag", {31'b0, bus_err}, 32'd1);
    check("tmo_info", bot_info, 32'h1122_3344);
    hang_info = 1'b0;
    base = tx_q.size();
    wait_txns(base + 1, 100, "tmo_resume_wait");
    check("tmo_resume_adr", tx_q[base].adr, 32'h14);
    enable = 1'b0;
    wait_idle(200, "tmo_post_idle");
    exp_upd++;
    check("tmo_upd", {16'b0, upd_count}, 32'(exp_upd));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_clear", {31'b0, bus_err}, 32'd0);
`endif

    // Enable drops during RD_INFO: the sequence still completes
    enable = 1'b0;
    wait_idle(100, "drop_pre_idle");
    base = tx_q.size();
    info_word = 32'h0506_0708;
    sync_sets++;
    enable = 1'b1;
    wait_xfer(32'h0C, 100, "drop_info_seen");
    enable = 1'b0;
    wait_idle(200, "drop_idle");
    exp_upd++;
    check("drop_txns", 32'(tx_q.size() - base), 32'd5);
    check("drop_last_adr", tx_q[base + 4].adr, 32'h10);
    check("drop_upd", {16'b0, upd_count}, 32'(exp_upd));
    check("drop_info", bot_info, 32'h0506_0708);
    check("drop_cyc", {31'b0, wb.cyc}, 32'd0);

    // Asynchronous reset in the middle of a transfer
    enable = 1'b1;
    wait_xfer(32'h14, 100, "arst_cyc_seen");
    #2;
    rstn = 1'b0;
    #1;
    check("arst_cyc",  {31'b0, wb.cyc}, 32'd0);
    check("arst_stb",  {31'b0, wb.stb}, 32'd0);
    check("arst_sel",  {28'b0, wb.sel}, 32'd0);
    check("arst_adr",  wb.adr, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_upd",  {16'b0, upd_count}, 32'd0);
    check("arst_info", bot_info, 32'd0);
    tick(2);
    rstn = 1'b1;
    base = tx_q.size();
    wait_txns(base + 1, 100, "arst_first_wait");
    check("arst_first_adr", tx_q[base].adr, 32'h14);
    check("arst_first_we", {31'b0, tx_q[base].we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
